// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_t        : FSM encoding (IDLE, BUSY, DONE)
//   DEFAULT_WIDTH  : default operand/result width
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle of the serial subtractor.
//   start, a, b, bin : request and operands (driven by the master)
//   ready, busy, done: FSM status, exactly one high per cycle
//   d, bout          : registered difference and borrow-out
//
// Handshake: a request is accepted on a rising edge where start and ready
// are both high; a, b and bin are captured on that edge only. start on any
// other edge is ignored. done is a one-cycle pulse marking d/bout valid; the
// result then holds until the next operation completes.
import serial_subtractor_pkg::*;

interface serial_subtractor_if #(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bout;

  modport master (
    output start, a, b, bin,
    input  ready, busy, done, d, bout
  );

  modport slave (
    input  start, a, b, bin,
    output ready, busy, done, d, bout
  );
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: x - y - bin.
//   x, y, bin : minuend bit, subtrahend bit, borrow-in
//   d, bout   : difference bit, borrow-out
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes (a - b - bin) mod 2^WIDTH and the final
// borrow, one bit per clock, LSB first.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : request/result bundle (slave side)
//   dbg_state  : current FSM state, for observation
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_subtractor_if.slave   bus,
  output state_t               dbg_state
);

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr, b_sr, diff_sr, diff_next;
  logic             borrow_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] d_q;
  logic             bout_q;
  logic             fs_d, fs_bout;
  logic             last_bit;

  // Single full subtractor, fed from the LSB of the shift registers.
  full_subtractor u_fs (
    .x    (a_sr[0]),
    .y    (b_sr[0]),
    .bin  (borrow_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  // Difference bits enter at the MSB so after WIDTH shifts bit 0 is the LSB.
  assign diff_next = {fs_d, diff_sr[WIDTH-1:1]};
  assign last_bit  = (cnt_q == LAST_BIT);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = BUSY;
      BUSY:    if (last_bit)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    bus.ready = (state_q == IDLE);
    bus.busy  = (state_q == BUSY);
    bus.done  = (state_q == DONE);
  end

  // Datapath: operand capture, bit-serial processing, result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr     <= '0;
      b_sr     <= '0;
      diff_sr  <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      d_q      <= '0;
      bout_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_sr     <= bus.a;
            b_sr     <= bus.b;
            borrow_q <= bus.bin;
            diff_sr  <= '0;
            cnt_q    <= '0;
          end
        end
        BUSY: begin
          a_sr     <= a_sr >> 1;
          b_sr     <= b_sr >> 1;
          diff_sr  <= diff_next;
          borrow_q <= fs_bout;
          cnt_q    <= cnt_q + CW'(1);
          // Result registers only change on the edge that enters DONE.
          if (last_bit) begin
            d_q    <= diff_next;
            bout_q <= fs_bout;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.d     = d_q;
  assign bus.bout  = bout_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;
  import serial_subtractor_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  bit   mon_en;
  int   n_checks;
  int   n_pass;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(4)) bus4();
  serial_subtractor_if #(.WIDTH(8)) bus8();
  state_t st4, st8;

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus4),
    .dbg_state (st4)
  );

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus8),
    .dbg_state (st8)
  );

  // ---------------- reference model ----------------
  // Plain integer arithmetic: borrow is the sign of a - b - bin, difference
  // is that value reduced modulo 2^w.
  function automatic void ref_sub(input int w, input int a, input int b,
                                  input int bin, output logic [31:0] d,
                                  output logic bo);
    int diff;
    int m;
    diff = a - b - bin;
    m    = 1 << w;
    bo   = (diff < 0);
    d    = 32'(((diff % m) + m) % m);
  endfunction

  // ---------------- scoreboard (WIDTH=8) ----------------
  logic [8:0] exp_q[$];

  always @(negedge clk) begin
    if (mon_en) begin
      n_checks++;
      if ($countones({bus4.ready, bus4.busy, bus4.done}) != 1)
        $display("FAIL onehot4: got r/b/d=%b%b%b, want exactly one high", bus4.ready, bus4.busy, bus4.done);
      else n_pass++;
      n_checks++;
      if ($countones({bus8.ready, bus8.busy, bus8.done}) != 1)
        $display("FAIL onehot8: got r/b/d=%b%b%b, want exactly one high", bus8.ready, bus8.busy, bus8.done);
      else n_pass++;
      if (bus8.done) begin
        logic [8:0] e;
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL result8: done with no expected result, got bout=%b d=%0d", bus8.bout, bus8.d);
        end else begin
          e = exp_q.pop_front();
          if ({bus8.bout, bus8.d} !== e)
            $display("FAIL result8: got bout=%b d=%0d, want bout=%b d=%0d", bus8.bout, bus8.d, e[8], e[7:0]);
          else n_pass++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready4(input string name);
    for (int i = 0; i < 20 && !bus4.ready; i++) tick();
    n_checks++;
    if (bus4.ready !== 1'b1) $display("FAIL %s ready timeout: got %b, want 1", name, bus4.ready);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.bin = 1'b0;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.bin = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus4.ready, bus4.busy, bus4.done, bus4.bout, bus4.d} !== 8'b1000_0000)
      $display("FAIL reset4: got r/b/dn/bo/d=%b%b%b%b/%h, want 1000/0", bus4.ready, bus4.busy, bus4.done, bus4.bout, bus4.d);
    else n_pass++;
    n_checks++;
    if ({bus8.ready, bus8.busy, bus8.done, bus8.bout, bus8.d} !== 12'b1000_0000_0000)
      $display("FAIL reset8: got r/b/dn/bo/d=%b%b%b%b/%h, want 1000/0", bus8.ready, bus8.busy, bus8.done, bus8.bout, bus8.d);
    else n_pass++;
    n_checks++;
    if (st4 !== IDLE) $display("FAIL reset_state4: got %0d, want %0d", st4, IDLE);
    else n_pass++;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;
    tick();
    n_checks++;
    if (bus4.ready !== 1'b1) $display("FAIL post_reset_ready4: got %b, want 1", bus4.ready);
    else n_pass++;
  endtask

  // One WIDTH=4 operation with latency, hold and result checks.
  task automatic run4(input string name, input logic [3:0] a, input logic [3:0] b,
                      input logic bin, input logic [3:0] exp_d, input logic exp_bo);
    logic [3:0] d_prev;
    logic       bo_prev;
    int         n;
    wait_ready4(name);
    d_prev  = bus4.d;
    bo_prev = bus4.bout;
    bus4.a = a; bus4.b = b; bus4.bin = bin; bus4.start = 1'b1;
    tick();
    // Scramble inputs after acceptance; they must not matter.
    bus4.start = 1'b0;
    bus4.a = 4'($urandom); bus4.b = 4'($urandom); bus4.bin = 1'($urandom);
    n = 0;
    while (!bus4.done && n < 10) begin
      n_checks++;
      if ({bus4.bout, bus4.d} !== {bo_prev, d_prev})
        $display("FAIL %s hold: got bout=%b d=%h, want bout=%b d=%h", name, bus4.bout, bus4.d, bo_prev, d_prev);
      else n_pass++;
      tick();
      n++;
    end
    n_checks++;
    if (n != 4) $display("FAIL %s latency: got %0d edges, want 4", name, n);
    else n_pass++;
    n_checks++;
    if ({bus4.bout, bus4.d} !== {exp_bo, exp_d})
      $display("FAIL %s result: got bout=%b d=%h, want bout=%b d=%h", name, bus4.bout, bus4.d, exp_bo, exp_d);
    else n_pass++;
    tick();
    n_checks++;
    if ({bus4.ready, bus4.done} !== 2'b10)
      $display("FAIL %s return_idle: got ready=%b done=%b, want 1 0", name, bus4.ready, bus4.done);
    else n_pass++;
  endtask

  task automatic test_basic();
    run4("basic_9m3", 4'd9, 4'd3, 1'b0, 4'h6, 1'b0);
  endtask

  task automatic test_borrow();
    run4("borrow_3m9", 4'd3, 4'd9, 1'b0, 4'hA, 1'b1);
    run4("borrow_0m0m1", 4'd0, 4'd0, 1'b1, 4'hF, 1'b1);
  endtask

  task automatic test_abort();
    wait_ready4("abort");
    bus4.a = 4'd5; bus4.b = 4'd2; bus4.bin = 1'b0; bus4.start = 1'b1;
    tick();
    bus4.start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus4.ready, bus4.busy, bus4.done, bus4.bout, bus4.d} !== 8'b1000_0000)
      $display("FAIL abort_reset: got r/b/dn/bo/d=%b%b%b%b/%h, want 1000/0", bus4.ready, bus4.busy, bus4.done, bus4.bout, bus4.d);
    else n_pass++;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_checks++;
      if (bus4.done !== 1'b0) $display("FAIL abort_no_done: got done=%b, want 0", bus4.done);
      else n_pass++;
    end
    run4("abort_next", 4'd5, 4'd2, 1'b0, 4'h3, 1'b0);
  endtask

  task automatic test_start_held();
    logic [4:0]  q[$];
    logic [31:0] rd;
    logic        rb;
    logic [4:0]  e;
    int          last_done;
    int          ndone;
    last_done = -1;
    ndone = 0;
    wait_ready4("held");
    for (int c = 0; c < 60; c++) begin
      if (c < 42) begin
        bus4.start = 1'b1;
        bus4.a = 4'($urandom); bus4.b = 4'($urandom); bus4.bin = 1'($urandom);
      end else begin
        bus4.start = 1'b0;
      end
      if (bus4.start && bus4.ready) begin
        ref_sub(4, int'(bus4.a), int'(bus4.b), int'(bus4.bin), rd, rb);
        q.push_back({rb, rd[3:0]});
      end
      tick();
      if (bus4.done) begin
        n_checks++;
        if (q.size() == 0) begin
          $display("FAIL held result: unexpected done, got bout=%b d=%h", bus4.bout, bus4.d);
        end else begin
          e = q.pop_front();
          if ({bus4.bout, bus4.d} !== e)
            $display("FAIL held result: got bout=%b d=%h, want bout=%b d=%h", bus4.bout, bus4.d, e[4], e[3:0]);
          else n_pass++;
        end
        if (last_done >= 0) begin
          n_checks++;
          if (c - last_done != 6) $display("FAIL held spacing: got %0d, want 6", c - last_done);
          else n_pass++;
        end
        last_done = c;
        ndone++;
      end
    end
    n_checks++;
    if (ndone != 7 || q.size() != 0)
      $display("FAIL held count: got %0d dones (%0d pending), want 7 (0 pending)", ndone, q.size());
    else n_pass++;
  endtask

  task automatic test_random8();
    int          accepted;
    int          gap;
    int          cycles;
    logic [31:0] rd;
    logic        rb;
    accepted = 0;
    cycles = 0;
    gap = $urandom_range(0, 3);
    while (accepted < 1000 && cycles < 30000) begin
      bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.bin = 1'($urandom);
      if (bus8.ready) begin
        if (gap == 0) begin
          bus8.start = 1'b1;
          ref_sub(8, int'(bus8.a), int'(bus8.b), int'(bus8.bin), rd, rb);
          exp_q.push_back({rb, rd[7:0]});
          accepted++;
          gap = $urandom_range(0, 3);
        end else begin
          bus8.start = 1'b0;
          gap--;
        end
      end else begin
        // Stray requests while busy or done must be ignored.
        bus8.start = 1'($urandom_range(0, 1));
      end
      tick();
      cycles++;
    end
    bus8.start = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    tick();
    n_checks++;
    if (accepted != 1000 || exp_q.size() != 0)
      $display("FAIL random8 count: got %0d accepted, %0d pending, want 1000, 0", accepted, exp_q.size());
    else n_pass++;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_checks = 0;
    n_pass = 0;
    mon_en = 1'b0;
    test_reset();
    test_basic();
    test_borrow();
    test_abort();
    test_start_held();
    test_random8();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 4: operand and result width in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 a  input  WIDTH  minuend, captured when start is accepted.
REQ-006 b  input  WIDTH  subtrahend, captured when start is accepted.
REQ-007 bin  input  1  borrow-in, captured when start is accepted.
REQ-008 ready  output  1  high exactly while in IDLE.
REQ-009 busy  output  1  high exactly while in BUSY.
REQ-010 done  output  1  single-cycle pulse; high exactly while in DONE.
REQ-011 d  output  WIDTH  registered difference, (a - b - bin) mod 2^WIDTH.
REQ-012 bout  output  1  registered borrow-out; 1 iff a < b + bin (unsigned).

Function
REQ-013 FSM states: IDLE, BUSY, DONE.
REQ-014 IDLE: start=1 at an edge loads a, b and bin into internal shift registers and the borrow flop, clears the bit counter, and moves the FSM to BUSY.
REQ-015 IDLE: start=0 keeps the FSM in IDLE.
REQ-016 BUSY: each edge processes one bit, LSB first.
- difference bit = a_i ^ b_i ^ borrow
- borrow_next = (~a_i & b_i) | (~(a_i ^ b_i) & borrow)
- shift registers move right by one; the counter increments.
REQ-017 BUSY lasts exactly WIDTH edges; the WIDTH-th edge processes the MSB and moves the FSM to DONE.
REQ-018 The edge entering DONE loads d with the assembled difference and bout with the final borrow.
REQ-019 d and bout hold their previous values throughout BUSY.
REQ-020 d and bout stay stable from DONE until the next completed operation.
REQ-021 DONE lasts one cycle and then moves to IDLE unconditionally.
REQ-022 Latency: if start is accepted at edge T, done is high between edges T+WIDTH and T+WIDTH+1, and ready returns high after edge T+WIDTH+1.
REQ-023 start in BUSY or DONE is ignored and has no effect on the operation in flight or on later operations.
REQ-024 Changes on a, b or bin after the accepting edge do not affect the result.
REQ-025 Back-to-back: start=1 in the first IDLE cycle after DONE is accepted, so the throughput is one result per WIDTH+2 cycles.
REQ-026 ready, busy and done decode directly from the state register; exactly one of them is high in every cycle.

Reset
REQ-027 rst_n=0 immediately forces, independent of clk: state=IDLE, shift registers=0, borrow=0, counter=0, d=0, bout=0.
REQ-028 Output values during and after reset: ready=1, busy=0, done=0, d=0, bout=0.
REQ-029 Reset asserted during BUSY or DONE aborts the operation; no done pulse is produced for it.
REQ-030 First start accepted: the first rising edge with rst_n=1 and start=1.

Structure
REQ-031 Package serial_subtractor_pkg holds:
- state typedef (enum: IDLE, BUSY, DONE)
- constant for the default WIDTH.
REQ-032 The per-bit logic is one combinational sub-module, full_subtractor.
- inputs: x, y, bin
- outputs: d, bout
- instantiated once and reused every cycle.
REQ-033 The counter width is clog2(WIDTH+1).

Verification (WIDTH=4 unless stated)
REQ-034 a=9, b=3, bin=0, start pulse -> done exactly 4 edges after acceptance; d=6, bout=0.
REQ-035 a=3, b=9, bin=0 -> d=0xA, bout=1; then a=0, b=0, bin=1 -> d=0xF, bout=1.
REQ-036 start held high continuously, operands changed every cycle -> each result matches the operands sampled on the accepting edges only; done pulses spaced 6 cycles apart.
REQ-037 rst_n pulsed low after the 2nd BUSY edge of a=5, b=2 -> d=0, bout=0, ready=1 immediately, no done; the next operation a=5, b=2 gives d=3, bout=0.
REQ-038 WIDTH=8, 1000 random (a, b, bin) with random start gaps -> every (bout, d) equals the 9-bit result of a - b - bin; ready/busy/done are one-hot every cycle.
